// File: rtl/wb_dma_arbiter.sv
// Two-master, one-slave Wishbone B3 arbiter for the DMA local bus.
// Round-robin grant held for the whole cycle; a watchdog errors out hung strobes.
module wb_dma_arbiter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,

  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic            last_gnt, last_gnt_nxt;
  logic [TO_W-1:0] wd_cnt, wd_cnt_nxt;

  logic            g_cyc;
  logic            g_stb;
  logic            slv_resp;
  logic            wd_fire;

  // State, last winner and watchdog registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wd_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      wd_cnt   <= wd_cnt_nxt;
    end
  end

  // Arbitration: ties go to the master that did not win last.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_gnt)) state_nxt = GNT0;
        else if (m1_cyc_i)                       state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Granted master's cyc/stb, kept separate so the watchdog does not loop through the mux.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    case (state)
      GNT0: begin
        g_cyc = m0_cyc_i;
        g_stb = m0_stb_i;
      end
      GNT1: begin
        g_cyc = m1_cyc_i;
        g_stb = m1_stb_i;
      end
      default: begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
      end
    endcase
  end

  assign slv_resp  = s_ack_i | s_err_i | s_rty_i;
  assign wd_fire   = g_cyc & g_stb & ~slv_resp & (wd_cnt == WD_LAST);
  assign timeout_o = wd_fire;

  // Watchdog counts consecutive unanswered strobe cycles; a real response wins over expiry.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (!g_stb || slv_resp || wd_fire) wd_cnt_nxt = '0;
    else if (g_cyc)                    wd_cnt_nxt = wd_cnt + TO_W'(1);
  end

  // Bus mux and response routing.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        s_sel_o  = m0_sel_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = (s_err_i & m0_stb_i) | wd_fire;
        m0_rty_o = s_rty_i & m0_stb_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_sel_o  = m1_sel_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = (s_err_i & m1_stb_i) | wd_fire;
        m1_rty_o = s_rty_i & m1_stb_i;
        gnt_o    = 2'b10;
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Directed bench for wb_dma_arbiter: vector table plus burst, watchdog and reset sequences.
module tb_wb_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_rty;
  logic [1:0]  gnt;
  logic        tmo;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] M0_ADR = 32'h0000_0200;
  localparam logic [31:0] M0_DAT = 32'h1111_2222;
  localparam logic [31:0] M1_ADR = 32'h0000_0040;
  localparam logic [31:0] M1_DAT = 32'hDEAD_BEEF;
  localparam logic [31:0] RDAT   = 32'hCAFE_F00D;

  always #5 clk = ~clk;

  wb_dma_arbiter #(.TIMEOUT(16), .TO_W(16)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte), .m0_sel_i(m0_sel),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte), .m1_sel_i(m1_sel),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_cti_o(s_cti), .s_bte_o(s_bte), .s_sel_o(s_sel),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  typedef struct {
    logic [5:0]  in;   // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err}
    logic [1:0]  gnt;
    logic [5:0]  out;  // {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}
    logic [31:0] adr;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(input logic [5:0] i, input logic [1:0] g,
                               input logic [5:0] o, input logic [31:0] a);
    vec_t v;
    v.in = i; v.gnt = g; v.out = o; v.adr = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] i);
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = i;
  endtask

  // Advance to the next negedge, apply inputs, and let combinational outputs settle.
  task automatic step(input logic [5:0] i);
    @(negedge clk);
    drive(i);
    #1;
  endtask

  initial begin
    m0_we = 1'b0; m0_adr = M0_ADR; m0_dat = M0_DAT; m0_cti = 3'b000; m0_bte = 2'b00; m0_sel = 4'h3;
    m1_we = 1'b1; m1_adr = M1_ADR; m1_dat = M1_DAT; m1_cti = 3'b000; m1_bte = 2'b00; m1_sel = 4'hF;
    s_rdat = RDAT; s_rty = 1'b0;
    drive(6'b000000);

    vecs[0]  = mkv(6'b000000, 2'b00, 6'b000000, 32'h0);
    vecs[1]  = mkv(6'b001100, 2'b00, 6'b000000, 32'h0);
    vecs[2]  = mkv(6'b001100, 2'b10, 6'b110000, M1_ADR);
    vecs[3]  = mkv(6'b001100, 2'b10, 6'b110000, M1_ADR);
    vecs[4]  = mkv(6'b001110, 2'b10, 6'b110100, M1_ADR);
    vecs[5]  = mkv(6'b001010, 2'b10, 6'b100000, M1_ADR);
    vecs[6]  = mkv(6'b000000, 2'b10, 6'b000000, M1_ADR);
    vecs[7]  = mkv(6'b000000, 2'b00, 6'b000000, 32'h0);
    vecs[8]  = mkv(6'b111100, 2'b00, 6'b000000, 32'h0);
    vecs[9]  = mkv(6'b111110, 2'b01, 6'b111000, M0_ADR);
    vecs[10] = mkv(6'b001100, 2'b01, 6'b000000, M0_ADR);
    vecs[11] = mkv(6'b111100, 2'b00, 6'b000000, 32'h0);
    vecs[12] = mkv(6'b111101, 2'b10, 6'b110001, M1_ADR);
    vecs[13] = mkv(6'b110000, 2'b10, 6'b000000, M1_ADR);
    vecs[14] = mkv(6'b000000, 2'b00, 6'b000000, 32'h0);

    // Reset state
    #12;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_s", 32'({s_cyc, s_stb, s_we, s_cti, s_bte, s_sel}), 32'h0);
    chk("reset_m", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty, tmo}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, stb gating, round-robin, slave error
    for (int i = 0; i < 15; i++) begin
      logic [31:0] exp_wd, exp_rd0, exp_rd1;
      step(vecs[i].in);
      exp_wd  = (vecs[i].gnt == 2'b10) ? M1_DAT : (vecs[i].gnt == 2'b01) ? M0_DAT : 32'h0;
      exp_rd0 = (vecs[i].gnt == 2'b01) ? RDAT : 32'h0;
      exp_rd1 = (vecs[i].gnt == 2'b10) ? RDAT : 32'h0;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_out", i), 32'({s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}),
          32'(vecs[i].out));
      chk($sformatf("vec%0d_adr", i), s_adr, vecs[i].adr);
      chk($sformatf("vec%0d_wdat", i), s_wdat, exp_wd);
      chk($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].gnt == 2'b10));
      chk($sformatf("vec%0d_rdat", i), {m0_rdat ^ exp_rd0} | {m1_rdat ^ exp_rd1}, 32'h0);
      chk($sformatf("vec%0d_tmo", i), 32'(tmo), 32'h0);
    end

    // Round-robin over 8 transfers, both masters always requesting
    for (int t = 0; t < 8; t++) begin
      logic [1:0] g;
      g = (t % 2 == 0) ? 2'b01 : 2'b10;
      step(6'b111100);
      chk($sformatf("rr%0d_idle", t), 32'(gnt), 32'h0);
      step(6'b111110);
      chk($sformatf("rr%0d_gnt", t), 32'(gnt), 32'(g));
      chk($sformatf("rr%0d_ack", t), 32'({m1_ack, m0_ack}), 32'(g));
      step((g == 2'b01) ? 6'b001100 : 6'b110000);
      chk($sformatf("rr%0d_rel", t), 32'({gnt, s_cyc}), 32'({g, 1'b0}));
    end

    // Burst hold: m1 4-beat incrementing burst, m0 joins at beat 2
    step(6'b001100);
    chk("burst_idle", 32'(gnt), 32'h0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      m1_adr = 32'h100 + 32'(b * 4);
      m1_cti = (b == 3) ? 3'b111 : 3'b010;
      drive((b >= 1) ? 6'b111110 : 6'b001110);
      #1;
      chk($sformatf("burst%0d_gnt", b), 32'(gnt), 32'h2);
      chk($sformatf("burst%0d_adr", b), s_adr, 32'h100 + 32'(b * 4));
      chk($sformatf("burst%0d_cti", b), 32'(s_cti), (b == 3) ? 32'h7 : 32'h2);
      chk($sformatf("burst%0d_ack", b), 32'({m1_ack, m0_ack}), 32'h2);
    end
    m1_adr = M1_ADR; m1_cti = 3'b000;
    step(6'b110000);
    chk("burst_drop", 32'({gnt, s_cyc, m0_ack}), 32'({2'b10, 1'b0, 1'b0}));
    step(6'b110000);
    chk("burst_idle2", 32'(gnt), 32'h0);
    step(6'b110010);
    chk("burst_m0", 32'({gnt, m0_ack, m1_ack}), 32'({2'b01, 1'b1, 1'b0}));
    step(6'b000000);

    // Watchdog: 16 unanswered strobe cycles
    step(6'b110000);
    chk("wd_idle", 32'(gnt), 32'h0);
    for (int k = 1; k <= 17; k++) begin
      step(6'b110000);
      chk($sformatf("wd%0d_err", k), 32'({m0_err, tmo}), (k == 16) ? 32'h3 : 32'h0);
      chk($sformatf("wd%0d_m1", k), 32'({m1_err, m1_ack}), 32'h0);
    end
    step(6'b000000);
    step(6'b110000);
    chk("wd2_idle", 32'(gnt), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      step((k == 16) ? 6'b110010 : 6'b110000);
      chk($sformatf("wdack%0d", k), 32'({m0_ack, m0_err, tmo}), (k == 16) ? 32'h4 : 32'h0);
    end
    step(6'b000000);

    // Reset mid-burst, then tie after reset
    step(6'b001100);
    m1_cti = 3'b010;
    step(6'b001110);
    chk("rb_beat1", 32'({gnt, m1_ack}), 32'({2'b10, 1'b1}));
    step(6'b001110);
    rst_n = 1'b0;
    #1;
    chk("rb_gnt", 32'(gnt), 32'h0);
    chk("rb_s", 32'({s_cyc, s_stb, s_we, s_cti, s_bte, s_sel}), 32'h0);
    chk("rb_sadr", s_adr | s_wdat, 32'h0);
    chk("rb_m", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty, tmo}), 32'h0);
    chk("rb_mdat", m0_rdat | m1_rdat, 32'h0);
    m1_cti = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b111100);
    #1;
    chk("tie_idle", 32'(gnt), 32'h0);
    step(6'b111100);
    chk("tie_m0", 32'(gnt), 32'h1);
    step(6'b001100);
    chk("tie_rel", 32'({gnt, s_cyc}), 32'({2'b01, 1'b0}));
    step(6'b001100);
    chk("tie_gap", 32'(gnt), 32'h0);
    step(6'b001100);
    chk("tie_m1", 32'(gnt), 32'h2);
    step(6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
